trade_decision: RTL

TRADE_DECISION -- requirements
Module: trade_decision

---
 rtl/npu_pkg.sv | 21 ++
 rtl/trade_decision.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU trading datapath.
// Holds the trade_decision FSM state encoding, the order side encoding and
// the default widths used for the score, position and cooldown counters.
package npu_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int POS_W_DEF = 8;
  localparam int CD_W_DEF  = 16;

  // Explicit encodings so that waveform and debug tooling that predates the
  // enum can still decode the raw state bits.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

endpackage

// File: rtl/trade_decision.sv
// trade_decision: turns a signed score from the MAC chain into BUY/SELL
// order requests, subject to a position limit and a post-order cooldown.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   score_in/valid      signed score and its single-cycle qualifier
//   enable              0 blocks new decisions; a pending order is unaffected
//   buy/sell_threshold  signed decision thresholds (inclusive)
//   cooldown_cycles     idle cycles enforced after each accepted order
//   max_position        unsigned magnitude limit on the net position
//   order_valid/side    order request (side 1=BUY, 0=SELL)
//   order_ready         downstream acceptance
//   position            signed net position
//   drop_count          saturating count of discarded valid scores
//   busy                high whenever the FSM is not idle
//
// Handshake: order_valid/order_side are registered and, once raised, hold
// stable until a cycle where order_valid and order_ready are both high; the
// order is transferred on that rising edge and order_valid falls after it.
module trade_decision
  import npu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int POS_W = POS_W_DEF,
  parameter int CD_W  = CD_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] score_in,
  input  logic                    score_valid,
  input  logic                    enable,
  input  logic signed [ACC_W-1:0] buy_threshold,
  input  logic signed [ACC_W-1:0] sell_threshold,
  input  logic        [CD_W-1:0]  cooldown_cycles,
  input  logic        [POS_W-2:0] max_position,
  output logic                    order_valid,
  output logic                    order_side,
  input  logic                    order_ready,
  output logic signed [POS_W-1:0] position,
  output logic        [15:0]      drop_count,
  output logic                    busy
);

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  state_e                  state_q;
  logic       [CD_W-1:0]   cd_cnt;

  // One extra bit so that -max_position never overflows the compare.
  logic signed [POS_W:0]   pos_ext;
  logic signed [POS_W:0]   max_ext;
  logic                    buy_hit;
  logic                    sell_hit;
  logic                    can_buy;
  logic                    can_sell;
  logic                    eval;
  logic                    go_buy;
  logic                    go_sell;
  logic                    drop_evt;

  assign pos_ext  = {position[POS_W-1], position};
  assign max_ext  = {2'b00, max_position};
  assign buy_hit  = score_in >= buy_threshold;
  assign sell_hit = score_in <= sell_threshold;
  assign can_buy  = pos_ext < max_ext;
  assign can_sell = pos_ext > -max_ext;

  assign eval    = (state_q == ST_IDLE) && score_valid && enable;
  assign go_buy  = eval && buy_hit && !sell_hit && can_buy;
  assign go_sell = eval && sell_hit && !buy_hit && can_sell;

  // A score is a drop when it is thrown away for a reason the operator should
  // see: FSM busy, overlapping thresholds, or a hit blocked by the limit.
  // A disabled idle FSM discards silently.
  always_comb begin
    drop_evt = 1'b0;
    if (state_q == ST_IDLE) begin
      drop_evt = eval && ((buy_hit && sell_hit) ||
                          (buy_hit && !can_buy) ||
                          (sell_hit && !can_sell));
    end else begin
      drop_evt = score_valid;
    end
  end

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      order_valid <= 1'b0;
      order_side  <= SIDE_SELL;
      position    <= '0;
      drop_count  <= '0;
      cd_cnt      <= '0;
    end else begin
      if (drop_evt && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (go_buy) begin
            order_valid <= 1'b1;
            order_side  <= SIDE_BUY;
            state_q     <= ST_WAIT_ACK;
          end else if (go_sell) begin
            order_valid <= 1'b1;
            order_side  <= SIDE_SELL;
            state_q     <= ST_WAIT_ACK;
          end
        end

        ST_WAIT_ACK: begin
          if (order_valid && order_ready) begin
            order_valid <= 1'b0;
            position    <= (order_side == SIDE_BUY) ? position + POS_ONE
                                                    : position - POS_ONE;
            if (cooldown_cycles == '0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_COOLDOWN;
              cd_cnt  <= cooldown_cycles;
            end
          end
        end

        ST_COOLDOWN: begin
          // Loaded with N at acceptance, so COOLDOWN lasts exactly N cycles.
          if (cd_cnt <= CD_W'(1)) begin
            cd_cnt  <= '0;
            state_q <= ST_IDLE;
          end else begin
            cd_cnt <= cd_cnt - CD_W'(1);
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          order_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
